// File: rtl/inst_mem_resp.sv
// inst_mem_resp
// Instruction-memory responder at the far end of the PC/fetch interface.
// A fetch request is accepted from the PC register and held for WAIT_CYCLES
// wait states. The 32-bit instruction word is then returned with a one-cycle
// valid strobe. While the fetch is outstanding, a stall request holds the PC.
// A flush (branch or exception) abandons any fetch in flight. A side write
// port fills the backing store.
//
// Parameters
//   ADDR_WIDTH   word-address width; the store holds 2^ADDR_WIDTH words
//   WAIT_CYCLES  wait states per fetch (0..7)
//   NOP_WORD     word returned for a misaligned or out-of-range fetch
//
// Ports
//   clk           in   clock, rising edge
//   rst           in   synchronous, active-high reset
//   ce_i          in   fetch request this cycle
//   pc_i          in   fetch byte address
//   flush_i       in   abort any outstanding fetch
//   load_we_i     in   store write enable
//   load_addr_i   in   store write byte address
//   load_data_i   in   store write data
//   inst_o        out  fetched instruction (holds when not valid)
//   inst_valid_o  out  one-cycle strobe: inst_o is valid
//   err_o         out  error flag, qualified by inst_valid_o
//   stallreq_o    out  combinational stall request to pipeline control
module inst_mem_resp #(
  parameter int          ADDR_WIDTH  = 10,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic [31:0] pc_i,
  input  logic        flush_i,
  input  logic        load_we_i,
  input  logic [31:0] load_addr_i,
  input  logic [31:0] load_data_i,
  output logic [31:0] inst_o,
  output logic        inst_valid_o,
  output logic        err_o,
  output logic        stallreq_o
);

  localparam int         DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [2:0] WAIT_INIT = 3'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // The byte address has no bits above the store's word index.
  function automatic logic in_range(input logic [31:0] a);
    return (a[31:ADDR_WIDTH+2] == '0);
  endfunction

  function automatic logic fetch_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || !in_range(a);
  endfunction

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_cnt;
  logic [2:0]  w_cnt_nxt;
  logic [31:0] r_addr;
  logic [31:0] r_inst;
  logic        r_valid;
  logic        r_err;
  logic [31:0] r_store [DEPTH];

  logic                  w_accept;
  logic [31:0]           w_rd_addr;
  logic [ADDR_WIDTH-1:0] w_rd_idx;
  logic                  w_rd_err;
  logic                  w_unused_ok;

  // Write byte offsets carry no meaning for word writes.
  assign w_unused_ok = ^load_addr_i[1:0];

  assign w_accept = ((r_state == S_IDLE) || (r_state == S_RESP)) && ce_i && !flush_i;

  // With zero wait states, RESP is entered on the same edge that latches
  // the request. The read must therefore use pc_i rather than r_addr.
  assign w_rd_addr = w_accept ? pc_i : r_addr;
  assign w_rd_idx  = w_rd_addr[ADDR_WIDTH+1:2];
  assign w_rd_err  = fetch_err(w_rd_addr);

  assign stallreq_o = !flush_i &&
                      ((w_accept && (WAIT_CYCLES != 0)) ||
                       ((r_state == S_WAIT) && (r_cnt != 3'd1)));

  assign inst_o       = r_inst;
  assign inst_valid_o = r_valid;
  assign err_o        = r_err;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE, S_RESP: begin
        if (w_accept) begin
          if (WAIT_CYCLES == 0) begin
            w_state_nxt = S_RESP;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = WAIT_INIT;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        // The latched request always completes; ce_i and pc_i are ignored.
        w_cnt_nxt = r_cnt - 3'd1;
        if (r_cnt == 3'd1) begin
          w_state_nxt = S_RESP;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (flush_i) begin
      w_state_nxt = S_IDLE;
    end
  end

  // ---- request latch / response register stage ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
      r_inst  <= 32'h0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_valid <= (w_state_nxt == S_RESP);
      if (w_state_nxt == S_RESP) begin
        r_inst <= w_rd_err ? NOP_WORD : r_store[w_rd_idx];
        r_err  <= w_rd_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_addr <= pc_i;
    end
  end

  // ---- backing store write port ----
  // The store is written with a non-blocking assignment. A read on the same
  // edge therefore sees the old word. Out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (load_we_i && in_range(load_addr_i)) begin
      r_store[load_addr_i[ADDR_WIDTH+1:2]] <= load_data_i;
    end
  end

endmodule
